// File: rtl/mmu_tlb.sv
// mmu_tlb: virtual-to-physical address translation in front of cache_controller.
// A fully-associative TLB is looked up per request. A miss walks a single-level
// page table (PTE at ptbr + VPN*4) over a dedicated memory port. Hits or
// refilled translations issue a one-cycle read_mem/write_mem. Invalid PTEs and
// writes to read-only pages raise a one-cycle page_fault instead.
// Optional build macro MMU_BYPASS_EN adds input mmu_enable. It is sampled on
// accept; when it is 0 the request issues with phy_addr = virt_addr.
module mmu_tlb #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned PAGE_BITS   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] virt_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] ptbr,
  input  logic        tlb_flush,
`ifdef MMU_BYPASS_EN
  input  logic        mmu_enable,
`endif
  output logic        mmu_stall,
  output logic        page_fault,
  output logic [31:0] phy_addr,
  output logic        read_mem,
  output logic        write_mem,
  output logic [31:0] data_from_cpu,
  input  logic        ready_stall,
  output logic [31:0] pt_mem_addr,
  output logic        pt_mem_read_req,
  input  logic [31:0] pt_mem_data_in,
  input  logic        pt_mem_ready
);

  localparam int unsigned VPN_W = 32 - PAGE_BITS;
  localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_WALK_WAIT,
    S_ISSUE,
    S_FAULT
  } state_t;

  state_t r_state;

  // Latched request
  logic [31:0] r_va;
  logic        r_is_wr;
  logic [31:0] r_wdata;

  // Registered outputs
  logic [31:0] r_pa;
  logic [31:0] r_dout;
  logic        r_rd_pulse;
  logic        r_wr_pulse;
  logic        r_pf;
  logic [31:0] r_pt_addr;
  logic        r_pt_req;

  // TLB storage
  logic [TLB_ENTRIES-1:0] r_tlb_v;
  logic [TLB_ENTRIES-1:0] r_tlb_w;
  logic [VPN_W-1:0]       r_tlb_vpn [TLB_ENTRIES];
  logic [VPN_W-1:0]       r_tlb_ppn [TLB_ENTRIES];
  logic [IDX_W-1:0]       r_ptr;

  // Lookup / walk helpers
  logic [VPN_W-1:0] w_vpn;
  logic             w_hit;
  logic             w_hit_w;
  logic [VPN_W-1:0] w_hit_ppn;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_victim;
  logic [31:0]      w_pt_addr;
  logic             w_pte_v;
  logic             w_pte_w;
  logic [VPN_W-1:0] w_pte_ppn;
  logic             w_pte_fault;
  logic             w_refill;
  logic             w_xlate_on;
  logic             w_accept;
  logic             w_unused;

  assign w_vpn       = r_va[31:PAGE_BITS];
  assign w_pt_addr   = ptbr + 32'({w_vpn, 2'b00});
  assign w_pte_v     = pt_mem_data_in[0];
  assign w_pte_w     = pt_mem_data_in[1];
  assign w_pte_ppn   = pt_mem_data_in[31:PAGE_BITS];
  assign w_pte_fault = !w_pte_v || (r_is_wr && !w_pte_w);
  assign w_refill    = (r_state == S_WALK_WAIT) && pt_mem_ready && !w_pte_fault;
  assign w_victim    = w_free_found ? w_free_idx : r_ptr;
  assign w_accept    = (cpu_read || cpu_write) && !ready_stall;
  assign w_unused    = ^pt_mem_data_in[PAGE_BITS-1:2];

`ifdef MMU_BYPASS_EN
  logic r_en;
  assign w_xlate_on = r_en;
`else
  assign w_xlate_on = 1'b1;
`endif

  assign mmu_stall       = (r_state != S_IDLE);
  assign page_fault      = r_pf;
  assign phy_addr        = r_pa;
  assign read_mem        = r_rd_pulse;
  assign write_mem       = r_wr_pulse;
  assign data_from_cpu   = r_dout;
  assign pt_mem_addr     = r_pt_addr;
  assign pt_mem_read_req = r_pt_req;

  // Fully-associative match of the latched VPN against all valid entries
  always_comb begin
    w_hit     = 1'b0;
    w_hit_w   = 1'b0;
    w_hit_ppn = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (r_tlb_v[IDX_W'(i)] && (r_tlb_vpn[IDX_W'(i)] == w_vpn)) begin
        w_hit     = 1'b1;
        w_hit_w   = r_tlb_w[IDX_W'(i)];
        w_hit_ppn = r_tlb_ppn[IDX_W'(i)];
      end
    end
  end

  // Lowest-index invalid entry; scanning downward lets the lowest one win
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = TLB_ENTRIES; i > 0; i--) begin
      if (!r_tlb_v[IDX_W'(i - 1)]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i - 1);
      end
    end
  end

  // TLB refill and flush; flush wins over a coincident refill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tlb_v <= '0;
      r_ptr   <= '0;
    end else if (tlb_flush) begin
      r_tlb_v <= '0;
      r_ptr   <= '0;
    end else if (w_refill) begin
      r_tlb_v[w_victim]   <= 1'b1;
      r_tlb_w[w_victim]   <= w_pte_w;
      r_tlb_vpn[w_victim] <= w_vpn;
      r_tlb_ppn[w_victim] <= w_pte_ppn;
      if (!w_free_found) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  // Request FSM with registered cache-side and page-table-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_va       <= '0;
      r_is_wr    <= 1'b0;
      r_wdata    <= '0;
      r_pa       <= '0;
      r_dout     <= '0;
      r_rd_pulse <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_pf       <= 1'b0;
      r_pt_addr  <= '0;
      r_pt_req   <= 1'b0;
`ifdef MMU_BYPASS_EN
      r_en       <= 1'b0;
`endif
    end else begin
      r_rd_pulse <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_pf       <= 1'b0;
      r_pt_req   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_va    <= virt_addr;
            r_is_wr <= cpu_write;
            r_wdata <= cpu_wdata;
`ifdef MMU_BYPASS_EN
            r_en    <= mmu_enable;
`endif
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!w_xlate_on) begin
            r_pa    <= r_va;
            r_dout  <= r_wdata;
            r_state <= S_ISSUE;
          end else if (w_hit) begin
            if (r_is_wr && !w_hit_w) begin
              r_pf    <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pa    <= {w_hit_ppn, r_va[PAGE_BITS-1:0]};
              r_dout  <= r_wdata;
              r_state <= S_ISSUE;
            end
          end else begin
            r_pt_addr <= w_pt_addr;
            r_pt_req  <= 1'b1;
            r_state   <= S_WALK;
          end
        end
        S_WALK: begin
          r_state <= S_WALK_WAIT;
        end
        S_WALK_WAIT: begin
          if (pt_mem_ready) begin
            if (w_pte_fault) begin
              r_pf    <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pa    <= {w_pte_ppn, r_va[PAGE_BITS-1:0]};
              r_dout  <= r_wdata;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!ready_stall) begin
            r_rd_pulse <= !r_is_wr;
            r_wr_pulse <= r_is_wr;
            r_state    <= S_IDLE;
          end
        end
        S_FAULT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed and randomized transactions against a behavioural
// TLB/page-table model. Cycle numbers below count negedges after the accept
// edge (cycle 0 = first negedge after the accepting posedge).
module tb_mmu_tlb;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] virt_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_wdata;
  logic [31:0] ptbr;
  logic        tlb_flush;
  logic        mmu_stall;
  logic        page_fault;
  logic [31:0] phy_addr;
  logic        read_mem;
  logic        write_mem;
  logic [31:0] data_from_cpu;
  logic        ready_stall;
  logic [31:0] pt_mem_addr;
  logic        pt_mem_read_req;
  logic [31:0] pt_mem_data_in;
  logic        pt_mem_ready;
`ifdef MMU_BYPASS_EN
  logic        mmu_enable = 1'b1;
`endif

  always #5 clk = ~clk;

  mmu_tlb #(.TLB_ENTRIES(N), .PAGE_BITS(12)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .virt_addr       (virt_addr),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_wdata       (cpu_wdata),
    .ptbr            (ptbr),
    .tlb_flush       (tlb_flush),
`ifdef MMU_BYPASS_EN
    .mmu_enable      (mmu_enable),
`endif
    .mmu_stall       (mmu_stall),
    .page_fault      (page_fault),
    .phy_addr        (phy_addr),
    .read_mem        (read_mem),
    .write_mem       (write_mem),
    .data_from_cpu   (data_from_cpu),
    .ready_stall     (ready_stall),
    .pt_mem_addr     (pt_mem_addr),
    .pt_mem_read_req (pt_mem_read_req),
    .pt_mem_data_in  (pt_mem_data_in),
    .pt_mem_ready    (pt_mem_ready)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // TLB contents as a list of translations plus a round-robin pointer.
  bit          m_v   [N];
  bit          m_w   [N];
  logic [19:0] m_vpn [N];
  logic [19:0] m_ppn [N];
  int unsigned m_ptr;
  logic [31:0] m_last_pa;
  logic [31:0] m_last_data;
  logic [31:0] pt [int unsigned];  // page table by VPN; absent = PTE 0

  function automatic void m_flush();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic int m_find(input logic [19:0] vpn);
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  function automatic void m_refill(input logic [19:0] vpn, input logic [31:0] pte);
    int slot = -1;
    for (int i = 0; i < N; i++)
      if (!m_v[i]) begin slot = i; break; end
    if (slot < 0) begin
      slot  = int'(m_ptr);
      m_ptr = (m_ptr + 1) % N;
    end
    m_v[slot]   = 1'b1;
    m_w[slot]   = pte[1];
    m_vpn[slot] = vpn;
    m_ppn[slot] = pte[31:12];
  endfunction

  function automatic logic [31:0] get_pte(input logic [19:0] vpn);
    if (pt.exists(int'(vpn))) return pt[int'(vpn)];
    return 32'h0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_flush();
    @(negedge clk);
    tlb_flush = 1'b1;
    @(negedge clk);
    tlb_flush = 1'b0;
    m_flush();
  endtask

  // One CPU request from accept to completion, checked against the model.
  task automatic run_txn(input string tag, input logic [31:0] va, input bit wr,
                         input logic [31:0] wd, input int unsigned dly,
                         input int unsigned stall_in, input bit flush_at_ready);
    logic [19:0] vpn;
    logic [31:0] pte, exp_pa, exp_pt_addr, got_pt_addr, addr_at_ready, res_pa, res_data;
    int          idx, nom, exp_cyc, res_cyc, pt_cyc, n_pt, n_rd, n_wr, n_pf;
    int unsigned stall;
    bit          walk, fault, do_flush;

    vpn         = va[31:12];
    idx         = m_find(vpn);
    walk        = (idx < 0);
    pte         = get_pte(vpn);
    exp_pt_addr = ptbr + {10'd0, vpn, 2'b00};
    if (!walk) begin
      fault  = wr && !m_w[idx];
      exp_pa = {m_ppn[idx], va[11:0]};
      nom    = fault ? 1 : 2;
    end else begin
      fault  = !pte[0] || (wr && !pte[1]);
      exp_pa = {pte[31:12], va[11:0]};
      nom    = fault ? 3 + int'(dly) : 4 + int'(dly);
    end
    stall    = fault ? 0 : stall_in;
    exp_cyc  = nom + int'(stall);
    do_flush = flush_at_ready && walk;

    // model update
    if (do_flush) m_flush();
    else if (walk && !fault) m_refill(vpn, pte);
    if (!fault) begin
      m_last_pa   = exp_pa;
      m_last_data = wd;
    end

    @(negedge clk);
    check_eq({tag, ".idle"}, mmu_stall, 1'b0);
    virt_addr = va;
    cpu_wdata = wd;
    cpu_write = wr;
    cpu_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    virt_addr = $urandom;
    cpu_wdata = $urandom;
    if (stall > 0) ready_stall = 1'b1;

    res_cyc = -1; pt_cyc = -1; n_pt = 0; n_rd = 0; n_wr = 0; n_pf = 0;
    got_pt_addr = '0; addr_at_ready = '0; res_pa = '0; res_data = '0;
    for (int c = 0; c <= exp_cyc + 2; c++) begin
      @(negedge clk);
      if (c == 1) check_eq({tag, ".busy"}, mmu_stall, 1'b1);
      if (pt_mem_read_req) begin
        n_pt++;
        if (pt_cyc < 0) begin pt_cyc = c; got_pt_addr = pt_mem_addr; end
      end
      if (read_mem)   n_rd++;
      if (write_mem)  n_wr++;
      if (page_fault) n_pf++;
      if ((read_mem || write_mem || page_fault) && res_cyc < 0) begin
        res_cyc  = c;
        res_pa   = phy_addr;
        res_data = data_from_cpu;
      end
      if (walk && c == 2 + int'(dly)) begin
        addr_at_ready  = pt_mem_addr;
        pt_mem_ready   = 1'b1;
        pt_mem_data_in = pte;
        tlb_flush      = do_flush;
      end else begin
        pt_mem_ready   = 1'b0;
        pt_mem_data_in = $urandom;
        tlb_flush      = 1'b0;
      end
      if (stall > 0 && c == nom - 1 + int'(stall)) ready_stall = 1'b0;
    end
    pt_mem_ready = 1'b0;
    tlb_flush    = 1'b0;
    ready_stall  = 1'b0;

    check_eq({tag, ".pt_reqs"}, n_pt, walk ? 1 : 0);
    if (walk) begin
      check_eq({tag, ".pt_cyc"}, pt_cyc, 1);
      check_eq({tag, ".pt_addr"}, got_pt_addr, exp_pt_addr);
      check_eq({tag, ".pt_hold"}, addr_at_ready, exp_pt_addr);
    end
    check_eq({tag, ".res_cyc"}, res_cyc, exp_cyc);
    check_eq({tag, ".n_rd"}, n_rd, (!fault && !wr) ? 1 : 0);
    check_eq({tag, ".n_wr"}, n_wr, (!fault && wr) ? 1 : 0);
    check_eq({tag, ".n_pf"}, n_pf, fault ? 1 : 0);
    if (!fault) begin
      check_eq({tag, ".pa"}, res_pa, exp_pa);
      check_eq({tag, ".data"}, res_data, wd);
    end
    check_eq({tag, ".pa_hold"}, phy_addr, m_last_pa);
  endtask

  // Reset during S_WALK_WAIT, then a late PTE return that must be ignored.
  task automatic reset_mid_walk(input logic [31:0] va);
    int n_req = 0;
    int n_mem = 0;
    @(negedge clk);
    virt_addr = va;
    cpu_read  = 1'b1;
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pt_mem_read_req) n_req++;
      if (c >= 4 && (read_mem || write_mem || page_fault)) n_mem++;
      if (c == 3) rst_n = 1'b0;
      if (c == 4) begin
        check_eq("rst.phy_addr", phy_addr, 32'h0);
        check_eq("rst.data", data_from_cpu, 32'h0);
        check_eq("rst.pt_addr", pt_mem_addr, 32'h0);
        check_eq("rst.ctl", {27'd0, mmu_stall, page_fault, read_mem, write_mem, pt_mem_read_req}, 32'h0);
        rst_n = 1'b1;
      end
      if (c == 5) begin
        pt_mem_ready   = 1'b1;
        pt_mem_data_in = get_pte(va[31:12]);
      end else begin
        pt_mem_ready = 1'b0;
      end
    end
    check_eq("rst.walk_started", n_req, 1);
    check_eq("rst.late_ready", n_mem, 0);
    m_flush();
    m_last_pa   = '0;
    m_last_data = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; virt_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    ptbr = 32'h0001_0000; tlb_flush = 1'b0; ready_stall = 1'b0;
    pt_mem_data_in = '0; pt_mem_ready = 1'b0;
    m_flush(); m_last_pa = '0; m_last_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset.outs", {27'd0, mmu_stall, page_fault, read_mem, write_mem, pt_mem_read_req}, 32'h0);
    check_eq("reset.pa", phy_addr, 32'h0);
    check_eq("reset.pt_addr", pt_mem_addr, 32'h0);
    rst_n = 1'b1;

    // Directed walk / hit / permission cases
    pt[3] = 32'h0004_5003;
    run_txn("walk_rd", 32'h0000_3ABC, 1'b0, 32'h1111_2222, 1, 0, 1'b0);
    check_eq("walk_rd.const_pa", m_last_pa, 32'h0004_5ABC);
    run_txn("hit_rd", 32'h0000_3010, 1'b0, 32'h3333_4444, 0, 0, 1'b0);
    pt[5] = 32'h0006_7001;
    run_txn("ro_wr", 32'h0000_5000, 1'b1, 32'hCAFE_BABE, 0, 0, 1'b0);
    pt[6] = 32'h0006_7003;
    run_txn("rw_wr", 32'h0000_6000, 1'b1, 32'hCAFE_BABE, 2, 0, 1'b0);
    run_txn("hit_ro_wr_retry", 32'h0000_5004, 1'b1, 32'h5555_6666, 0, 0, 1'b0);
    pt[7] = 32'h0000_0000;
    run_txn("inval1", 32'h0000_7000, 1'b0, 32'h0, 0, 0, 1'b0);
    run_txn("inval2", 32'h0000_7000, 1'b0, 32'h0, 3, 0, 1'b0);

    // Flush then repeat the first VA; stall in S_ISSUE
    idle_flush();
    run_txn("flush_walk", 32'h0000_3ABC, 1'b0, 32'h7777_8888, 0, 0, 1'b0);
    run_txn("stall_hit", 32'h0000_3ABC, 1'b0, 32'h9999_AAAA, 0, 3, 1'b0);
    run_txn("stall_walk", 32'h0000_6123, 1'b1, 32'hBBBB_CCCC, 1, 2, 1'b0);

    // Replacement: 9 distinct pages into 8 entries
    idle_flush();
    for (int unsigned v = 32'h10; v <= 32'h18; v++) pt[v] = {12'h0A0, v[7:0], 12'h003};
    for (int unsigned v = 32'h10; v <= 32'h18; v++)
      run_txn($sformatf("fill%0h", v), {v[19:0], 12'h040}, 1'b0, $urandom, 0, 0, 1'b0);
    run_txn("evict_hit11", 32'h0001_1040, 1'b0, 32'h1, 0, 0, 1'b0);
    run_txn("evict_walk10", 32'h0001_0040, 1'b0, 32'h2, 0, 0, 1'b0);

    // Flush coinciding with refill: issue still happens, entry not kept
    pt[32'h20] = 32'h0ABC_D003;
    run_txn("flush_refill", 32'h0002_0FFC, 1'b0, 32'h3, 1, 0, 1'b1);
    run_txn("flush_refill_again", 32'h0002_0FFC, 1'b0, 32'h4, 0, 0, 1'b0);

    // Reset mid-walk, then the same VA walks again
    idle_flush();
    reset_mid_walk(32'h0000_3ABC);
    run_txn("post_rst", 32'h0000_3ABC, 1'b0, 32'h5, 0, 0, 1'b0);

    // Page-table address wraps past 2^32
    ptbr = 32'hFFFF_FFF0;
    pt[32'h30] = 32'h0123_4003;
    run_txn("wrap", 32'h0003_0456, 1'b1, 32'h6, 0, 0, 1'b0);

    // Randomized traffic over a 12-page working set
    for (int unsigned v = 32'h40; v < 32'h4C; v++) begin
      logic [31:0] r;
      r = $urandom;
      pt[v] = {r[31:12], 10'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
    end
    for (int k = 0; k < 150; k++) begin
      logic [31:0] va;
      va = {12'd0, 8'h40 + 8'($urandom_range(0, 11)), 12'($urandom)};
      if ($urandom_range(0, 19) == 0) idle_flush();
      if ($urandom_range(0, 9) == 0) ptbr = {$urandom, 2'b00};
      run_txn($sformatf("rnd%0d", k), va, 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
